// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose:
//   Watches the pins of a multiplexed, active-low 4-digit 7-segment display.
//   It recovers the hex value and decimal points being shown.
//   Each digit is sampled once per stable scan interval, after the synced pins
//   have been quiet for STABLE_CYC cycles. Decoded digits are collected in a
//   shadow frame. Once all four digits are present, the frame is published on
//   Hex/point with a one-cycle valid pulse.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   AN           in   4   digit enables, active-low (AN[i]=0 selects digit i)
//   SEG          in   8   segments, active-low, SEG[6:0]=g..a, SEG[7]=dp
//   Hex          out  16  last complete frame, Hex[4i+3:4i] = digit i
//   point        out  4   last frame decimal points, 1 = lit
//   valid        out  1   one-cycle pulse when Hex/point update
//   err          out  1   sticky, an undecodable glyph was sampled
//   stale        out  1   no frame completed within TIMEOUT cycles
//   o_dbg_state  out  2   current scan FSM state (IDLE=0, SETTLE=1, HELD=2)
//
// Handshake:
//   valid is a pure strobe with no ready. Hex/point are valid in the cycle
//   valid is high and hold that value until the next pulse.
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEG,
  output logic [15:0] Hex,
  output logic [3:0]  point,
  output logic        valid,
  output logic        err,
  output logic        stale,
  output logic [1:0]  o_dbg_state
);

  localparam int              TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      CNT_LAST = 8'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Synchronizer and previous-value register.
  logic [3:0]  r_an_s1;
  logic [3:0]  r_an_s2;
  logic [7:0]  r_seg_s1;
  logic [7:0]  r_seg_s2;
  logic [11:0] r_prev;

  // Scan FSM.
  state_t      r_state;
  logic [7:0]  r_cnt;

  // Frame assembly.
  logic [15:0] r_shadow_hex;
  logic [3:0]  r_shadow_dp;
  logic [3:0]  r_captured;
  logic [15:0] r_hex;
  logic [3:0]  r_point;
  logic        r_valid;
  logic        r_err;

  // Stale watchdog.
  logic [TO_W-1:0] r_to_cnt;
  logic            r_stale;

  // Combinational helpers.
  logic        w_changed;
  logic        w_stable_end;
  logic        w_sel_ok;
  logic [1:0]  w_sel_idx;
  logic        w_dec_ok;
  logic [3:0]  w_dec_nib;
  logic        w_sample;
  logic        w_bad;
  logic        w_frame_done;
  logic [3:0]  w_cap_next;

  // Map lit segments {g,f,e,d,c,b,a} to a nibble.
  // Bit 4 of the result says whether the glyph is legal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
    logic [4:0] res;
    res = 5'b0_0000;
    case (lit)
      7'h3F:   res = 5'b1_0000;
      7'h06:   res = 5'b1_0001;
      7'h5B:   res = 5'b1_0010;
      7'h4F:   res = 5'b1_0011;
      7'h66:   res = 5'b1_0100;
      7'h6D:   res = 5'b1_0101;
      7'h7D:   res = 5'b1_0110;
      7'h07:   res = 5'b1_0111;
      7'h7F:   res = 5'b1_1000;
      7'h6F:   res = 5'b1_1001;
      7'h77:   res = 5'b1_1010;
      7'h7C:   res = 5'b1_1011;
      7'h39:   res = 5'b1_1100;
      7'h5E:   res = 5'b1_1101;
      7'h79:   res = 5'b1_1110;
      7'h71:   res = 5'b1_1111;
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // 2-flop synchronizer. It idles at all ones, which is the blank display.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_s1  <= 4'hF;
      r_an_s2  <= 4'hF;
      r_seg_s1 <= 8'hFF;
      r_seg_s2 <= 8'hFF;
      r_prev   <= 12'hFFF;
    end else begin
      r_an_s1  <= AN;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= SEG;
      r_seg_s2 <= r_seg_s1;
      r_prev   <= {r_an_s2, r_seg_s2};
    end
  end

  assign w_changed = ({r_an_s2, r_seg_s2} != r_prev);

  // ---------------------------------------------------------------------------
  // Sample qualification.
  // A digit is eligible only when exactly one enable is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_sel_ok  = 1'b1;
    w_sel_idx = 2'd0;
    case (r_an_s2)
      4'b1110: w_sel_idx = 2'd0;
      4'b1101: w_sel_idx = 2'd1;
      4'b1011: w_sel_idx = 2'd2;
      4'b0111: w_sel_idx = 2'd3;
      default: w_sel_ok  = 1'b0;
    endcase
  end

  assign {w_dec_ok, w_dec_nib} = decode_glyph(~r_seg_s2[6:0]);

  assign w_stable_end = (r_state == SETTLE) && !w_changed && (r_cnt == CNT_LAST);
  assign w_sample     = w_stable_end && w_sel_ok && w_dec_ok;
  assign w_bad        = w_stable_end && w_sel_ok && !w_dec_ok;
  assign w_frame_done = (r_captured == 4'hF);

  // Publishing a frame clears captured.
  // A sample in that same cycle then starts the new frame with its own bit.
  always_comb begin
    w_cap_next = w_frame_done ? 4'h0 : r_captured;
    if (w_sample) begin
      w_cap_next[w_sel_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM.
  // Any change of the synced pins restarts settling, whatever the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else if (w_changed) begin
      r_state <= SETTLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            // The sample (if any) is taken in this cycle by the frame logic.
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HELD: begin
          r_state <= HELD;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame assembly and publishing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_hex <= 16'h0000;
      r_shadow_dp  <= 4'h0;
      r_captured   <= 4'h0;
      r_hex        <= 16'h0000;
      r_point      <= 4'h0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_valid    <= w_frame_done;
      r_captured <= w_cap_next;
      if (w_frame_done) begin
        // The shadow read here is the old value.
        // A same-cycle sample lands in the next frame.
        r_hex   <= r_shadow_hex;
        r_point <= r_shadow_dp;
      end
      if (w_sample) begin
        r_shadow_hex[{w_sel_idx, 2'b00} +: 4] <= w_dec_nib;
        r_shadow_dp[w_sel_idx]                <= ~r_seg_s2[7];
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stale watchdog.
  // It saturates at TIMEOUT. A published frame takes priority and clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_frame_done) begin
      r_to_cnt <= '0;
      r_stale  <= 1'b0;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      r_stale  <= ((r_to_cnt + 1'b1) == TO_MAX);
    end else begin
      r_stale  <= 1'b1;
    end
  end

  assign Hex         = r_hex;
  assign point       = r_point;
  assign valid       = r_valid;
  assign err         = r_err;
  assign stale       = r_stale;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Purpose:
//   Self-checking bench for seg_scan_decoder with STABLE_CYC = 4 and
//   TIMEOUT = 64.
//   Expected frames {point, Hex} are queued as digits are scanned. They are
//   popped and compared whenever the DUT pulses valid.
//   Segment codes are built from the glyph letter strings.
// -----------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int STABLE_CYC = 4;
  localparam int TIMEOUT    = 64;

  logic        clk;
  logic        rst_n;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic [15:0] Hex;
  logic [3:0]  point;
  logic        valid;
  logic        err;
  logic        stale;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_bad;
  int n_valid;
  logic prev_valid;
  logic [19:0] exp_q[$];

  string glyphs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  seg_scan_decoder #(
    .STABLE_CYC (STABLE_CYC),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .AN          (AN),
    .SEG         (SEG),
    .Hex         (Hex),
    .point       (point),
    .valid       (valid),
    .err         (err),
    .stale       (stale),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-low SEG byte for hex digit d, optionally with the dp lit.
  function automatic logic [7:0] seg_code(input int d, input bit dp);
    string s;
    logic [6:0] lit;
    int b;
    s   = glyphs[d];
    lit = 7'd0;
    for (int k = 0; k < s.len(); k++) begin
      b = int'(s[k]) - 97;
      lit[b] = 1'b1;
    end
    return {~dp, ~lit};
  endfunction

  // Driver tasks. Entry and exit are both 1 time unit after a rising edge.
  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    AN  = an;
    SEG = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_raw(input int idx, input logic [7:0] seg, input int n);
    logic [3:0] an;
    an      = 4'b1111;
    an[idx] = 1'b0;
    hold(an, seg, n);
  endtask

  task automatic scan_digit(input int idx, input int val, input bit dp, input int n);
    scan_raw(idx, seg_code(val, dp), n);
  endtask

  task automatic idle(input int n);
    hold(4'b1111, 8'hFF, n);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    for (int c = 0; c < bound; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard consumer. Every valid pulse must match the head of the queue.
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid === 1'b1) begin
        n_valid++;
        check("valid_pulse_width", prev_valid, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("frame", {point, Hex}, exp_q.pop_front());
        end
      end
      prev_valid = valid;
    end
  end

  initial begin
    int saved_valid;
    n_cmp   = 0;
    n_bad   = 0;
    n_valid = 0;
    rst_n   = 1'b0;
    AN      = 4'hF;
    SEG     = 8'hFF;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", Hex, 16'h0000);
    check("rst_point", point, 4'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_stale", stale, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // Basic frame: 1,0,3,2 on digits 3..0 with no decimal points.
    exp_q.push_back({4'b0000, 16'h1032});
    scan_digit(3, 1, 1'b0, 8);
    scan_digit(2, 0, 1'b0, 8);
    scan_digit(1, 3, 1'b0, 8);
    scan_digit(0, 2, 1'b0, 8);
    idle(2);
    wait_drain("frame1_drain", 20);
    check("frame1_hex_hold", Hex, 16'h1032);
    check("frame1_point", point, 4'h0);
    check("frame1_err", err, 1'b0);

    // Digit 2 is shown for only 2 cycles, so it must not be captured.
    saved_valid = n_valid;
    scan_digit(3, 5, 1'b0, 8);
    scan_digit(2, 6, 1'b0, 2);
    scan_digit(1, 7, 1'b1, 8);
    scan_digit(0, 8, 1'b0, 8);
    idle(10);
    check("short_digit_no_valid", n_valid, saved_valid);
    check("short_digit_hex_hold", Hex, 16'h1032);
    exp_q.push_back({4'b0010, 16'h5678});
    scan_digit(2, 6, 1'b0, 8);
    idle(2);
    wait_drain("frame2_drain", 20);

    // Illegal glyph "abg" on digit 1.
    saved_valid = n_valid;
    scan_digit(3, 10, 1'b0, 8);
    scan_digit(2, 11, 1'b0, 8);
    scan_raw(1, 8'b1011_1100, 8);
    scan_digit(0, 12, 1'b0, 8);
    idle(10);
    check("bad_glyph_err", err, 1'b1);
    check("bad_glyph_no_valid", n_valid, saved_valid);
    // Only digit 1 is missing. Scanning it completes the frame.
    exp_q.push_back({4'b0000, 16'hABEC});
    scan_digit(1, 14, 1'b0, 8);
    idle(2);
    wait_drain("frame3_drain", 20);
    check("err_sticky", err, 1'b1);
    check("stale_after_valid", stale, 1'b0);

    // Blank display long enough to time out.
    saved_valid = n_valid;
    idle(TIMEOUT + 10);
    check("timeout_stale", stale, 1'b1);
    check("timeout_hex_hold", Hex, 16'hABEC);
    check("timeout_no_valid", n_valid, saved_valid);
    exp_q.push_back({4'b1000, 16'h0123});
    scan_digit(3, 0, 1'b1, 8);
    scan_digit(2, 1, 1'b0, 8);
    scan_digit(1, 2, 1'b0, 8);
    scan_digit(0, 3, 1'b0, 8);
    idle(2);
    wait_drain("frame4_drain", 20);
    check("stale_cleared", stale, 1'b0);
    check("err_still_sticky", err, 1'b1);

    // Reset after three digits have been captured.
    scan_digit(2, 7, 1'b0, 8);
    scan_digit(1, 7, 1'b0, 8);
    scan_digit(0, 7, 1'b0, 8);
    idle(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hex", Hex, 16'h0000);
    check("async_rst_point", point, 4'h0);
    check("async_rst_valid", valid, 1'b0);
    check("async_rst_err", err, 1'b0);
    check("async_rst_stale", stale, 1'b0);
    AN  = 4'hF;
    SEG = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    // Digit 3 alone must not complete a frame; earlier captures are gone.
    saved_valid = n_valid;
    scan_digit(3, 15, 1'b0, 8);
    idle(10);
    check("post_rst_no_valid", n_valid, saved_valid);
    exp_q.push_back({4'b0001, 16'hFEDC});
    scan_digit(2, 14, 1'b0, 8);
    scan_digit(1, 13, 1'b0, 8);
    scan_digit(0, 12, 1'b1, 8);
    idle(2);
    wait_drain("frame5_drain", 20);
    check("frame5_point_hold", point, 4'b0001);
    check("frame5_err", err, 1'b0);

    idle(5);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
